// File: rtl/lrhls_mul_pipe.sv
// Pipelined multiplier with valid/ready handshake, per-operand signedness, post-product shift.
// Optional output saturation is enabled by defining LRHLS_MUL_SAT_EN; otherwise the result wraps.
module lrhls_mul_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 15,
  parameter int A_SIGNED  = 1,
  parameter int B_SIGNED  = 0,
  parameter int P_WIDTH   = 33,
  parameter int SHIFT     = 0,
  parameter int NUM_STAGE = 3
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] din0,
  input  logic [B_WIDTH-1:0] din1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] dout,
  output logic               ovf
);

  localparam int FW = A_WIDTH + B_WIDTH;
  // Two guard bits let an unsigned FW-bit product and the saturation limits live in one signed type.
  localparam int EW = FW + 2;

`ifdef LRHLS_MUL_SAT_EN
  localparam bit P_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
  localparam logic signed [EW-1:0] ONE = EW'(1);
  localparam logic signed [EW-1:0] SAT_MAX =
    P_SIGNED ? ((ONE <<< (P_WIDTH - 1)) - ONE) : ((ONE <<< P_WIDTH) - ONE);
  localparam logic signed [EW-1:0] SAT_MIN =
    P_SIGNED ? -(ONE <<< (P_WIDTH - 1)) : {EW{1'b0}};
`endif

  function automatic logic signed [EW-1:0] ext_a(input logic [A_WIDTH-1:0] a);
    logic sb;
    sb = (A_SIGNED != 0) && a[A_WIDTH-1];
    return {{(EW-A_WIDTH){sb}}, a};
  endfunction

  function automatic logic signed [EW-1:0] ext_b(input logic [B_WIDTH-1:0] b);
    logic sb;
    sb = (B_SIGNED != 0) && b[B_WIDTH-1];
    return {{(EW-B_WIDTH){sb}}, b};
  endfunction

  // Returns {ovf, dout}. The shift floors because the product is held sign-correct in EW bits.
  function automatic logic [P_WIDTH:0] shift_narrow(input logic signed [EW-1:0] p);
    logic signed [EW-1:0] s;
    s = p >>> SHIFT;
`ifdef LRHLS_MUL_SAT_EN
    if (s > SAT_MAX) return {1'b1, SAT_MAX[P_WIDTH-1:0]};
    if (s < SAT_MIN) return {1'b1, SAT_MIN[P_WIDTH-1:0]};
`endif
    return {1'b0, s[P_WIDTH-1:0]};
  endfunction

  logic [NUM_STAGE-1:0]  r_vld_p;
  logic                  w_ce;
  logic                  w_xfer;
  logic                  w_fin_vld;
  logic signed [EW-1:0]  w_fin_prod;
  logic [P_WIDTH:0]      w_nar;
  logic [P_WIDTH-1:0]    r_dout;
  logic                  r_ovf;

  assign w_ce     = !r_vld_p[NUM_STAGE-1] || out_ready;
  assign in_ready = ap_rst_n && w_ce;
  assign w_xfer   = in_valid && in_ready;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_vld_p <= '0;
    end else if (w_ce) begin
      r_vld_p[0] <= w_xfer;
      for (int i = 1; i < NUM_STAGE; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  generate
    if (NUM_STAGE == 1) begin : g_comb
      assign w_fin_prod = ext_a(din0) * ext_b(din1);
      assign w_fin_vld  = w_xfer;
    end else begin : g_reg
      logic [A_WIDTH-1:0]   r_a_p0;
      logic [B_WIDTH-1:0]   r_b_p0;
      logic signed [EW-1:0] w_prod_p1;

      // stage p0: raw operands
      always_ff @(posedge ap_clk) begin
        if (w_ce) begin
          r_a_p0 <= din0;
          r_b_p0 <= din1;
        end
      end

      assign w_prod_p1 = ext_a(r_a_p0) * ext_b(r_b_p0);
      assign w_fin_vld = r_vld_p[NUM_STAGE-2];

      if (NUM_STAGE == 2) begin : g_d2
        assign w_fin_prod = w_prod_p1;
      end else begin : g_dn
        logic signed [EW-1:0] r_prod_p [NUM_STAGE-2];

        // stages p1..: full-width product, then plain delay
        always_ff @(posedge ap_clk) begin
          if (w_ce) begin
            r_prod_p[0] <= w_prod_p1;
            for (int i = 1; i < NUM_STAGE - 2; i++) r_prod_p[i] <= r_prod_p[i-1];
          end
        end

        assign w_fin_prod = r_prod_p[NUM_STAGE-3];
      end
    end
  endgenerate

  assign w_nar = shift_narrow(w_fin_prod);

  // final stage: narrowed result drives the outputs directly
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_dout <= '0;
      r_ovf  <= 1'b0;
    end else if (w_ce && w_fin_vld) begin
      r_dout <= w_nar[P_WIDTH-1:0];
      r_ovf  <= w_nar[P_WIDTH];
    end
  end

  assign out_valid = r_vld_p[NUM_STAGE-1];
  assign dout      = r_dout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_lrhls_mul_pipe.sv
// Bench for lrhls_mul_pipe: four configurations checked against an arithmetic scoreboard model.
module tb_lrhls_mul_pipe;

  localparam int AW_T [4] = '{18, 8, 18, 18};
  localparam int BW_T [4] = '{15, 8, 15, 15};
  localparam int AS_T [4] = '{1, 1, 1, 1};
  localparam int BS_T [4] = '{0, 1, 0, 0};
  localparam int PW_T [4] = '{33, 16, 16, 16};
  localparam int SH_T [4] = '{0, 0, 0, 4};
  localparam int NS_T [4] = '{3, 1, 3, 3};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv0, ir0, ov0, or0, f0;
  logic [17:0] a0;
  logic [14:0] b0;
  logic [32:0] d0;
  logic        iv1, ir1, ov1, or1, f1;
  logic [7:0]  a1, b1;
  logic [15:0] d1;
  logic        iv2, ir2, ov2, or2, f2;
  logic [17:0] a2;
  logic [14:0] b2;
  logic [15:0] d2;
  logic        iv3, ir3, ov3, or3, f3;
  logic [17:0] a3;
  logic [14:0] b3;
  logic [15:0] d3;

  lrhls_mul_pipe u_def (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .din0(a0), .din1(b0),
    .out_valid(ov0), .out_ready(or0), .dout(d0), .ovf(f0));

  lrhls_mul_pipe #(.A_WIDTH(8), .B_WIDTH(8), .A_SIGNED(1), .B_SIGNED(1), .P_WIDTH(16),
                   .SHIFT(0), .NUM_STAGE(1)) u_s1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .din0(a1), .din1(b1),
    .out_valid(ov1), .out_ready(or1), .dout(d1), .ovf(f1));

  lrhls_mul_pipe #(.P_WIDTH(16), .SHIFT(0)) u_p16 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .din0(a2), .din1(b2),
    .out_valid(ov2), .out_ready(or2), .dout(d2), .ovf(f2));

  lrhls_mul_pipe #(.P_WIDTH(16), .SHIFT(4)) u_p16s4 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .din0(a3), .din1(b3),
    .out_valid(ov3), .out_ready(or3), .dout(d3), .ovf(f3));

  typedef struct {
    longint pat;
    bit     ovf;
    int     cyc;
    bit     lat;
  } exp_t;

  exp_t        q [4][$];
  bit          lat_en [4];
  bit          stl [4];
  logic [63:0] pd [4];
  int          n_out [4];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
  endtask

  function automatic longint ival(input logic [63:0] v, input int w, input bit s);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    if (s && v[w-1]) return longint'(v | ~m);
    return longint'(v & m);
  endfunction

  // Exact product, floor shift, then clamp or wrap to the output width.
  function automatic void model(input int id, input longint a, input longint b,
                                output longint pat, output bit o);
    longint s;
    s = (a * b) >>> SH_T[id];
    o = 1'b0;
`ifdef LRHLS_MUL_SAT_EN
    begin
      longint mx, mn;
      if (AS_T[id] != 0 || BS_T[id] != 0) begin
        mx = (64'sd1 <<< (PW_T[id] - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
      end else begin
        mx = (64'sd1 <<< PW_T[id]) - 64'sd1;
        mn = 64'sd0;
      end
      if (s > mx) begin s = mx; o = 1'b1; end
      else if (s < mn) begin s = mn; o = 1'b1; end
    end
`endif
    pat = s & ((64'sd1 <<< PW_T[id]) - 64'sd1);
  endfunction

  task automatic mon(input int id, input bit rn, input bit iv, input bit ir,
                     input logic [63:0] a, input logic [63:0] b, input bit ov, input bit ordy,
                     input logic [63:0] d, input bit f);
    exp_t e;
    if (!rn) begin
      chk($sformatf("rst_in_ready[%0d]", id), longint'(ir), 0);
      q[id].delete();
      stl[id] = 1'b0;
      return;
    end
    chk($sformatf("in_ready[%0d]", id), longint'(ir), longint'(!ov || ordy));
    if (ov && !ordy) begin
      if (stl[id]) chk($sformatf("stall_hold[%0d]", id), longint'(d), longint'(pd[id]));
      stl[id] = 1'b1;
      pd[id] = d;
    end else begin
      stl[id] = 1'b0;
    end
    if (ov && ordy) begin
      chk($sformatf("out_has_input[%0d]", id), longint'(q[id].size() > 0), 1);
      if (q[id].size() > 0) begin
        e = q[id].pop_front();
        chk($sformatf("dout[%0d]", id), longint'(d), e.pat);
        chk($sformatf("ovf[%0d]", id), longint'(f), longint'(e.ovf));
        if (e.lat) chk($sformatf("latency[%0d]", id), longint'(cyc - e.cyc), longint'(NS_T[id]));
        n_out[id]++;
      end
    end
    if (iv && ir) begin
      model(id, ival(a, AW_T[id], AS_T[id] != 0), ival(b, BW_T[id], BS_T[id] != 0), e.pat, e.ovf);
      e.cyc = cyc;
      e.lat = lat_en[id];
      q[id].push_back(e);
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst_n, iv0, ir0, 64'(a0), 64'(b0), ov0, or0, 64'(d0), f0);
    mon(1, rst_n, iv1, ir1, 64'(a1), 64'(b1), ov1, or1, 64'(d1), f1);
    mon(2, rst_n, iv2, ir2, 64'(a2), 64'(b2), ov2, or2, 64'(d2), f2);
    mon(3, rst_n, iv3, ir3, 64'(a3), 64'(b3), ov3, or3, 64'(d3), f3);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    longint mp;
    bit     mo;
    int     base, i, t;

    model(0, -131072, 32767, mp, mo);
    chk("model_pin_neg", mp, 64'sd4295098368);
    model(0, 131071, 32767, mp, mo);
    chk("model_pin_pos", mp, 64'sd4294803457);
    model(1, -128, -128, mp, mo);
    chk("model_pin_s1", mp, 16384);
    model(3, 1000, 100, mp, mo);
    chk("model_pin_shift", mp, 6250);

    for (int k = 0; k < 4; k++) lat_en[k] = 1'b1;
    rst_n = 1'b0;
    {iv0, iv1, iv2, iv3} = '0;
    {or0, or1, or2, or3} = '1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
    tick(3);
    chk("rst_out_valid", longint'(ov0), 0);
    chk("rst_dout", longint'(d0), 0);
    chk("rst_ovf", longint'(f0), 0);
    rst_n = 1'b1;

    // Defaults, no stall
    iv0 = 1'b1; a0 = 18'h20000; b0 = 15'd32767;
    tick(1);
    a0 = 18'd131071;
    tick(1);
    iv0 = 1'b0;
    tick(1);
    chk("def_first_valid", longint'(ov0), 1);
    chk("def_first_dout", longint'($signed(d0)), -64'sd4294836224);
    chk("def_first_ovf", longint'(f0), 0);
    tick(1);
    chk("def_second_dout", longint'($signed(d0)), 64'sd4294803457);
    tick(4);

    // Single-stage signed stream
    iv1 = 1'b1; a1 = 8'h80; b1 = 8'h80;
    tick(1);
    chk("s1_valid", longint'(ov1), 1);
    chk("s1_dout_a", longint'($signed(d1)), 16384);
    a1 = 8'hFF; b1 = 8'd5;
    tick(1);
    chk("s1_dout_b", longint'($signed(d1)), -5);
    a1 = 8'd127; b1 = 8'h80;
    tick(1);
    chk("s1_dout_c", longint'($signed(d1)), -16256);
    iv1 = 1'b0;
    tick(1);
    chk("s1_idle_valid", longint'(ov1), 0);
    tick(3);

    // Narrow output: saturate/wrap and shift
    iv2 = 1'b1; iv3 = 1'b1;
    a2 = 18'd1000; b2 = 15'd100; a3 = 18'd1000; b3 = 15'd100;
    tick(1);
    a2 = 18'h3FC18; a3 = 18'h3FC18;
    tick(1);
    a2 = 18'd100; a3 = 18'd100;
    tick(1);
    iv2 = 1'b0; iv3 = 1'b0;
`ifdef LRHLS_MUL_SAT_EN
    chk("p16_pos_dout", longint'($signed(d2)), 32767);
    chk("p16_pos_ovf", longint'(f2), 1);
`else
    chk("p16_pos_dout", longint'($signed(d2)), -31072);
    chk("p16_pos_ovf", longint'(f2), 0);
`endif
    chk("p16s4_pos_dout", longint'($signed(d3)), 6250);
    chk("p16s4_pos_ovf", longint'(f3), 0);
    tick(1);
`ifdef LRHLS_MUL_SAT_EN
    chk("p16_neg_dout", longint'($signed(d2)), -32768);
`else
    chk("p16_neg_dout", longint'($signed(d2)), 31072);
`endif
    chk("p16s4_neg_dout", longint'($signed(d3)), -6250);
    tick(1);
    chk("p16_mid_dout", longint'($signed(d2)), 10000);
    chk("p16_mid_ovf", longint'(f2), 0);
    chk("p16s4_mid_dout", longint'($signed(d3)), 625);
    tick(4);

    // Backpressure: 0..19 x 3, five stalled cycles mid-stream
    lat_en[0] = 1'b0;
    base = n_out[0];
    i = 0;
    t = 0;
    while (i < 20 && t < 200) begin
      or0 = !(t >= 6 && t < 11);
      iv0 = 1'b1; a0 = 18'(i); b0 = 15'd3;
      @(negedge clk);
      if (ir0) i++;
      tick(1);
      t++;
    end
    iv0 = 1'b0; or0 = 1'b1;
    chk("bp_all_accepted", longint'(i), 20);
    tick(8);
    chk("bp_all_delivered", longint'(n_out[0] - base), 20);
    lat_en[0] = 1'b1;

    // Reset with a full, stalled pipeline
    iv0 = 1'b1; a0 = 18'd11; b0 = 15'd13;
    tick(1);
    a0 = 18'd2; b0 = 15'd2;
    tick(1);
    a0 = 18'd5; b0 = 15'd5;
    tick(1);
    iv0 = 1'b0; or0 = 1'b0;
    chk("pre_rst_full", longint'(ov0), 1);
    tick(1);
    chk("pre_rst_in_ready", longint'(ir0), 0);
    rst_n = 1'b0;
    #2;
    chk("rst_low_in_ready", longint'(ir0), 0);
    tick(1);
    chk("post_rst_valid", longint'(ov0), 0);
    chk("post_rst_dout", longint'(d0), 0);
    rst_n = 1'b1; or0 = 1'b1;
    iv0 = 1'b1; a0 = 18'd7; b0 = 15'd9;
    tick(1);
    iv0 = 1'b0;
    tick(1);
    chk("post_rst_early", longint'(ov0), 0);
    tick(1);
    chk("post_rst_new_valid", longint'(ov0), 1);
    chk("post_rst_new_dout", longint'(d0), 63);
    tick(10);

    for (int k = 0; k < 4; k++) chk($sformatf("drained[%0d]", k), longint'(q[k].size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
